// File: rtl/param_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : param_serializer_if
// Purpose  : Load/shift handshake bundle between the TX FSM and the serializer.
// Revision : 1.0
// ============================================================================
interface param_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Ready;
    logic                  Ser_En;
    logic                  Ser_Clr;
    logic                  Ser_Data;
    logic                  Ser_Done;
    logic                  Busy;
    logic                  Par_Bit;

    modport master (
        output P_DATA,
        output Data_Valid,
        output Ser_En,
        output Ser_Clr,
        input  Ready,
        input  Ser_Data,
        input  Ser_Done,
        input  Busy,
        input  Par_Bit
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  Ser_En,
        input  Ser_Clr,
        output Ready,
        output Ser_Data,
        output Ser_Done,
        output Busy,
        output Par_Bit
    );
endinterface
`default_nettype wire

// File: rtl/param_serializer.sv
`default_nettype none
// ============================================================================
// Module   : param_serializer
// Purpose  : Parallel-to-serial shifter with stall, synchronous abort and parity.
// Revision : 1.0
// ============================================================================
module param_serializer #(
    parameter int   DATA_WIDTH = 8,
    parameter bit   MSB_FIRST  = 1'b0,
    parameter bit   PAR_TYPE   = 1'b0,
    parameter logic IDLE_VAL   = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    param_serializer_if.slave  bus
);

    localparam int                 c_cnt_w = $clog2(DATA_WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_ser_data;
    logic                  r_last;
    logic                  r_done;
    logic                  r_par;

    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [c_cnt_w-1:0]    w_cnt_nxt;
    logic                  w_ser_data_nxt;
    logic                  w_last_nxt;
    logic                  w_done_nxt;
    logic                  w_par_nxt;
    logic [c_cnt_w-1:0]    w_idx;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_idx = c_last - r_cnt;
        end else begin : g_lsb_first
            assign w_idx = r_cnt;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_ser_data <= IDLE_VAL;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
            r_par      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ser_data <= w_ser_data_nxt;
            r_last     <= w_last_nxt;
            r_done     <= w_done_nxt;
            r_par      <= w_par_nxt;
        end
    end

    // IDLE is re-entered as the final bit appears so a new word can load
    // immediately; Done trails that final bit by one cycle via r_last.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_cnt_nxt      = r_cnt;
        w_ser_data_nxt = r_ser_data;
        w_last_nxt     = 1'b0;
        w_done_nxt     = r_last;
        w_par_nxt      = r_par;

        if (bus.Ser_Clr) begin
            w_state_nxt    = ST_IDLE;
            w_shift_nxt    = '0;
            w_cnt_nxt      = '0;
            w_ser_data_nxt = IDLE_VAL;
            w_done_nxt     = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.Data_Valid) begin
                        w_shift_nxt = bus.P_DATA;
                        w_par_nxt   = (^bus.P_DATA) ^ PAR_TYPE;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bus.Ser_En) begin
                        w_ser_data_nxt = r_shift[w_idx];
                        if (r_cnt == c_last) begin
                            w_state_nxt = ST_IDLE;
                            w_last_nxt  = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Ready    = (r_state == ST_IDLE);
    assign bus.Busy     = (r_state == ST_SHIFT);
    assign bus.Ser_Data = r_ser_data;
    assign bus.Ser_Done = r_done;
    assign bus.Par_Bit  = r_par;

    a_ready_busy: assert property (@(posedge clk) disable iff (!rst_n)
        bus.Ready != bus.Busy);
    a_done_single: assert property (@(posedge clk) disable iff (!rst_n)
        bus.Ser_Done |=> !bus.Ser_Done);
    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        r_cnt <= c_last);

endmodule
`default_nettype wire

// File: tb/tb_param_serializer.sv
`default_nettype none
// Bench for param_serializer: table of words on an 8-bit LSB-first instance with a bit
// scoreboard, plus directed sequences on MSB-first and 16-bit odd-parity instances.
module tb_param_serializer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    param_serializer_if #(.DATA_WIDTH(8))  bus_a ();
    param_serializer_if #(.DATA_WIDTH(8))  bus_b ();
    param_serializer_if #(.DATA_WIDTH(16)) bus_c ();

    param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .PAR_TYPE(1'b0), .IDLE_VAL(1'b0))
        u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .PAR_TYPE(1'b0), .IDLE_VAL(1'b0))
        u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    param_serializer #(.DATA_WIDTH(16), .MSB_FIRST(1'b0), .PAR_TYPE(1'b1), .IDLE_VAL(1'b0))
        u_dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         stall_at;
        int         stall_len;
        int         done_cyc;
    } vec_t;

    vec_t vecs[5];
    logic exp_q[$];
    logic pend_a = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a shift strobed in one cycle must show its bit on Ser_Data the next.
    always @(negedge clk) begin
        if (pend_a && rst_n) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_scoreboard: got a shifted bit, expected no pending bit");
            end else begin
                check("a_ser_data", {31'd0, bus_a.Ser_Data}, {31'd0, exp_q.pop_front()});
            end
        end
        pend_a = rst_n && bus_a.Ser_En && bus_a.Busy && !bus_a.Ser_Clr;
    end

    task automatic send_a(input logic [7:0] d, input int stall_at, input int stall_len,
                          output int done_cyc);
        int cyc;
        bus_a.P_DATA     = d;
        bus_a.Data_Valid = 1'b1;
        bus_a.Ser_En     = 1'b0;
        step();
        cyc = 1;
        bus_a.Data_Valid = 1'b0;
        check("a_busy_after_load", bus_a.Busy, 1);
        check("a_ready_after_load", bus_a.Ready, 0);
        for (int k = 0; k < 8; k++) exp_q.push_back(d[k]);
        for (int k = 0; k < 8; k++) begin
            bus_a.Ser_En = 1'b1;
            step();
            cyc++;
            if (k == stall_at) begin
                bus_a.Ser_En = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    cyc++;
                    check("a_stall_hold", bus_a.Ser_Data, d[k]);
                    check("a_stall_busy", bus_a.Busy, 1);
                end
            end
        end
        bus_a.Ser_En = 1'b0;
        check("a_ready_after_last", bus_a.Ready, 1);
        check("a_done_early", bus_a.Ser_Done, 0);
        while (bus_a.Ser_Done !== 1'b1 && cyc < 60) begin
            step();
            cyc++;
        end
        done_cyc = cyc;
        step();
        check("a_done_one_cycle", bus_a.Ser_Done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        int   dc;
        int   done_cnt;
        logic b_seq[8];
        logic [15:0] c_word;

        vecs[0] = '{8'hC1, 1'b1, -1, 0, 10};
        vecs[1] = '{8'hA5, 1'b0,  3, 3, 13};
        vecs[2] = '{8'h00, 1'b0, -1, 0, 10};
        vecs[3] = '{8'hFF, 1'b0,  6, 1, 11};
        vecs[4] = '{8'h80, 1'b1,  0, 2, 12};

        bus_a.P_DATA = '0; bus_a.Data_Valid = 1'b0; bus_a.Ser_En = 1'b0; bus_a.Ser_Clr = 1'b0;
        bus_b.P_DATA = '0; bus_b.Data_Valid = 1'b0; bus_b.Ser_En = 1'b0; bus_b.Ser_Clr = 1'b0;
        bus_c.P_DATA = '0; bus_c.Data_Valid = 1'b0; bus_c.Ser_En = 1'b0; bus_c.Ser_Clr = 1'b0;

        step();
        step();
        check("rst_ready", bus_a.Ready, 1);
        check("rst_busy", bus_a.Busy, 0);
        check("rst_ser_data", bus_a.Ser_Data, 0);
        check("rst_done", bus_a.Ser_Done, 0);
        check("rst_par", bus_a.Par_Bit, 0);
        check("rst_c_ready", bus_c.Ready, 1);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", bus_a.Ready, 1);

        // Table of words on instance A
        for (int i = 0; i < 5; i++) begin
            send_a(vecs[i].data, vecs[i].stall_at, vecs[i].stall_len, dc);
            check("a_par", bus_a.Par_Bit, vecs[i].par);
            check("a_done_cycle", dc, vecs[i].done_cyc);
            check("a_sb_drained", exp_q.size(), 0);
        end

        // Abort after bit 4 of 0xFF
        bus_a.P_DATA = 8'hFF;
        bus_a.Data_Valid = 1'b1;
        step();
        bus_a.Data_Valid = 1'b0;
        for (int k = 0; k < 8; k++) exp_q.push_back(1'b1);
        bus_a.Ser_En = 1'b1;
        repeat (5) step();
        bus_a.Ser_Clr = 1'b1;
        step();
        bus_a.Ser_Clr = 1'b0;
        bus_a.Ser_En  = 1'b0;
        exp_q.delete();
        check("clr_ser_data", bus_a.Ser_Data, 0);
        check("clr_ready", bus_a.Ready, 1);
        check("clr_busy", bus_a.Busy, 0);
        for (int s = 0; s < 3; s++) begin
            check("clr_no_done", bus_a.Ser_Done, 0);
            step();
        end
        send_a(8'h01, -1, 0, dc);
        check("after_clr_par", bus_a.Par_Bit, 1);
        check("after_clr_done_cycle", dc, 10);

        // Abort together with a load request in IDLE: load refused, parity held
        bus_a.P_DATA = 8'h03;
        bus_a.Data_Valid = 1'b1;
        bus_a.Ser_Clr = 1'b1;
        step();
        bus_a.Data_Valid = 1'b0;
        bus_a.Ser_Clr = 1'b0;
        check("clr_valid_ready", bus_a.Ready, 1);
        check("clr_valid_busy", bus_a.Busy, 0);
        check("clr_valid_par_hold", bus_a.Par_Bit, 1);
        step();

        // Asynchronous reset mid-word, then a clean 0x3C
        bus_a.P_DATA = 8'h5B;
        bus_a.Data_Valid = 1'b1;
        step();
        bus_a.Data_Valid = 1'b0;
        for (int k = 0; k < 8; k++) exp_q.push_back(bus_a.P_DATA[k]);
        bus_a.Ser_En = 1'b1;
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_ser_data", bus_a.Ser_Data, 0);
        check("arst_busy", bus_a.Busy, 0);
        check("arst_ready", bus_a.Ready, 1);
        check("arst_par", bus_a.Par_Bit, 0);
        bus_a.Ser_En = 1'b0;
        step();
        step();
        exp_q.delete();
        rst_n = 1'b1;
        step();
        send_a(8'h3C, -1, 0, dc);
        check("arst_3c_par", bus_a.Par_Bit, 0);
        check("arst_3c_done_cycle", dc, 10);
        check("arst_sb_drained", exp_q.size(), 0);

        // MSB-first instance, 0xC1
        b_seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bus_b.P_DATA = 8'hC1;
        bus_b.Data_Valid = 1'b1;
        step();
        bus_b.Data_Valid = 1'b0;
        bus_b.Ser_En = 1'b1;
        done_cnt = 0;
        for (int c = 2; c <= 12; c++) begin
            step();
            if (c <= 9) check("b_ser_data", bus_b.Ser_Data, b_seq[c-2]);
            if (bus_b.Ser_Done === 1'b1) begin
                done_cnt++;
                check("b_done_cycle", c, 10);
                check("b_busy_at_done", bus_b.Busy, 0);
            end
        end
        bus_b.Ser_En = 1'b0;
        check("b_done_count", done_cnt, 1);
        check("b_par", bus_b.Par_Bit, 1);
        check("b_ser_data_hold", bus_b.Ser_Data, 1);

        // 16-bit odd parity, load request while busy must be ignored
        c_word = 16'h8001;
        bus_c.P_DATA = c_word;
        bus_c.Data_Valid = 1'b1;
        step();
        bus_c.Data_Valid = 1'b0;
        bus_c.Ser_En = 1'b1;
        check("c_par", bus_c.Par_Bit, 1);
        done_cnt = 0;
        for (int c = 2; c <= 20; c++) begin
            bus_c.Data_Valid = (c == 5);
            bus_c.P_DATA     = (c == 5) ? 16'h0007 : c_word;
            step();
            if (c <= 17) check("c_ser_data", bus_c.Ser_Data, c_word[c-2]);
            if (c == 10) check("c_busy_mid", bus_c.Busy, 1);
            if (bus_c.Ser_Done === 1'b1) begin
                done_cnt++;
                check("c_done_cycle", c, 18);
            end
        end
        bus_c.Data_Valid = 1'b0;
        bus_c.Ser_En = 1'b0;
        check("c_done_count", done_cnt, 1);
        check("c_par_after", bus_c.Par_Bit, 1);
        check("c_idle_after", bus_c.Busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
